mux_stream_arb: RTL and testbench
=================================

Name: mux_stream_arb

Overview:
- Parametrised N-input, W-bit stream multiplexer with one registered output stage and valid/ready handshakes on every channel.
- Generalises the combinational 4-to-1 case mux:
  - width and input count are parameters;
  - channel selection is either explicit (sel) or round-robin arbitration;
  - the selected word is held in an output register until the consumer accepts it.
- Sits between several producers and a single consumer.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- MODE, 0, 0 = MODE_SEL (explicit sel), 1 = MODE_RR (round-robin); elaboration-time constant.
- SEL_W, $clog2(NUM_IN), width of sel and out_chan; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; one-hot or zero.
- sel  input  SEL_W  channel select; used only in MODE_SEL.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_chan  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_chan=0, RR pointer ptr=0. An assertion mid-transfer clears these immediately; the held word is dropped.
- load = !out_valid || out_ready. The output stage is free when it is empty or being drained this cycle.
- Grant in MODE_SEL:
  - gnt = sel, but only when sel < NUM_IN and in_valid[sel].
  - Otherwise there is no grant.
- Grant in MODE_RR:
  - gnt is the first i with in_valid[i]=1, scanning ptr, ptr+1, … modulo NUM_IN.
  - If no valid is asserted, there is no grant.
- in_ready[i] = load && grant exists && gnt==i. Its value is combinational from in_valid, sel, ptr, out_valid and out_ready.
- Transfer occurs on a clock edge where in_ready[i] && in_valid[i]:
  - out_data <= channel i data;
  - out_chan <= i;
  - out_valid <= 1.
  - In MODE_RR only, ptr <= (i+1) mod NUM_IN, which wraps correctly for non-power-of-2 NUM_IN.
- Drain without refill: if out_valid && out_ready and no transfer occurs, out_valid <= 0. out_data and out_chan keep their last value.
- Stall: if out_valid && !out_ready, out_data, out_chan and ptr hold, and all in_ready are 0. Changes on sel or in_valid have no effect on the held word.
- Timing and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word/cycle while out_ready=1.
  - Simultaneous drain and refill in the same cycle is required; no bubble is allowed.
- Illegal sel: in MODE_SEL with sel >= NUM_IN, no in_ready is asserted and no transfer occurs.
- Fairness: in MODE_RR, each continuously valid channel is granted at least once every NUM_IN transfers.
- Unused logic:
  - In MODE_SEL, ptr is not instantiated, or is tied to 0.
  - In MODE_RR, sel is ignored.

Decomposition:
- Package mux_pkg:
  - MODE_SEL=0 and MODE_RR=1 constants;
  - a function clog2_min1 returning max(1, $clog2(n)).
- Sub-module rr_arbiter (NUM_IN parameter):
  - inputs: req[NUM_IN], ptr[SEL_W];
  - outputs: gnt_valid, gnt_idx[SEL_W];
  - purely combinational, rotate-priority.
- mux_stream_arb owns ptr, the output register and the handshake logic.

Test Plan:
- Reset: assert rst mid-stream while out_valid=1 with out_data=32'hDEAD_BEEF -> out_valid, out_data and out_chan are 0 asynchronously, before the next clk edge; ptr=0 after release.
- MODE_SEL basic: NUM_IN=4, sel=2, in_valid=4'b0100, in_data ch2=32'h0000_00C2, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hC2, out_chan=2.
- MODE_SEL backpressure and illegal sel:
  - out_ready=0 with out_valid=1, then change sel 2->1 -> out_data holds 32'hC2 and in_ready=0.
  - With NUM_IN=3 and sel=3 -> no transfer for 5 cycles.
- MODE_RR fairness: NUM_IN=4, all in_valid=1, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
- MODE_RR skip and wrap: NUM_IN=3, ptr=2, in_valid=3'b011 -> grant ch0, ptr becomes 1; next grant ch1, ptr becomes 2.
- Drain-and-refill: out_valid=1, out_ready=1, in_valid on ch1 in the same cycle -> out_data replaced next cycle, out_valid stays 1, exactly one transfer counted.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
package mux_pkg;

    localparam int unsigned MODE_SEL = 0;
    localparam int unsigned MODE_RR  = 1;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first request at or after ptr wins.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    localparam int unsigned SUM_W = SEL_W + 1;

    logic [SUM_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester is the final winner.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
            cand = SUM_W'(ptr) + SUM_W'(k);
            if (cand >= SUM_W'(NUM_IN)) begin
                cand = cand - SUM_W'(NUM_IN);
            end
            if (req[cand[SEL_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_stream_arb.sv
// N-input stream multiplexer with explicit-select or round-robin grant and one output register.
module mux_stream_arb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned MODE   = MODE_SEL,
    parameter int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_chan
);

    logic             load;
    logic             xfer;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // Output stage can accept when empty or being drained this cycle.
    assign load     = !out_valid || out_ready;
    assign xfer     = load && gnt_valid;
    assign in_ready = xfer ? (NUM_IN'(1) << gnt_idx) : '0;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] ptr;
        logic             unused_sel;

        assign unused_sel = ^sel;

        rr_arbiter #(
            .NUM_IN (NUM_IN),
            .SEL_W  (SEL_W)
        ) u_arb (
            .req       (in_valid),
            .ptr       (ptr),
            .gnt_valid (gnt_valid),
            .gnt_idx   (gnt_idx)
        );

        // Priority pointer moves just past the channel that last transferred.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ptr <= '0;
            end else if (xfer) begin
                ptr <= (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
            end
        end
    end else begin : g_sel
        // Explicit select; an out-of-range sel matches no channel and never grants.
        always_comb begin
            gnt_valid = 1'b0;
            gnt_idx   = sel;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: refill on transfer, otherwise empty when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_chan  <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb in select and round-robin modes, 3 and 4 channels.
module tb_mux_stream_arb;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // MODE_SEL, 4 channels
    logic [4*W-1:0] s4_in_data;
    logic [3:0]     s4_in_valid, s4_in_ready;
    logic [1:0]     s4_sel, s4_out_chan;
    logic [W-1:0]   s4_out_data;
    logic           s4_out_valid, s4_out_ready;

    // MODE_SEL, 3 channels
    logic [3*W-1:0] s3_in_data;
    logic [2:0]     s3_in_valid, s3_in_ready;
    logic [1:0]     s3_sel, s3_out_chan;
    logic [W-1:0]   s3_out_data;
    logic           s3_out_valid, s3_out_ready;

    // MODE_RR, 4 channels
    logic [4*W-1:0] r4_in_data;
    logic [3:0]     r4_in_valid, r4_in_ready;
    logic [1:0]     r4_sel, r4_out_chan;
    logic [W-1:0]   r4_out_data;
    logic           r4_out_valid, r4_out_ready;

    // MODE_RR, 3 channels
    logic [3*W-1:0] r3_in_data;
    logic [2:0]     r3_in_valid, r3_in_ready;
    logic [1:0]     r3_sel, r3_out_chan;
    logic [W-1:0]   r3_out_data;
    logic           r3_out_valid, r3_out_ready;

    mux_stream_arb #(.WIDTH(W), .NUM_IN(4), .MODE(0)) u_s4 (
        .clk(clk), .rst(rst), .in_data(s4_in_data), .in_valid(s4_in_valid),
        .in_ready(s4_in_ready), .sel(s4_sel), .out_data(s4_out_data),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_chan(s4_out_chan));

    mux_stream_arb #(.WIDTH(W), .NUM_IN(3), .MODE(0)) u_s3 (
        .clk(clk), .rst(rst), .in_data(s3_in_data), .in_valid(s3_in_valid),
        .in_ready(s3_in_ready), .sel(s3_sel), .out_data(s3_out_data),
        .out_valid(s3_out_valid), .out_ready(s3_out_ready), .out_chan(s3_out_chan));

    mux_stream_arb #(.WIDTH(W), .NUM_IN(4), .MODE(1)) u_r4 (
        .clk(clk), .rst(rst), .in_data(r4_in_data), .in_valid(r4_in_valid),
        .in_ready(r4_in_ready), .sel(r4_sel), .out_data(r4_out_data),
        .out_valid(r4_out_valid), .out_ready(r4_out_ready), .out_chan(r4_out_chan));

    mux_stream_arb #(.WIDTH(W), .NUM_IN(3), .MODE(1)) u_r3 (
        .clk(clk), .rst(rst), .in_data(r3_in_data), .in_valid(r3_in_valid),
        .in_ready(r3_in_ready), .sel(r3_sel), .out_data(r3_out_data),
        .out_valid(r3_out_valid), .out_ready(r3_out_ready), .out_chan(r3_out_chan));

    task automatic test_reset();
        rst = 1'b1;
        s4_in_data = '0; s4_in_valid = '0; s4_sel = '0; s4_out_ready = 1'b0;
        s3_in_data = '0; s3_in_valid = '0; s3_sel = '0; s3_out_ready = 1'b0;
        r4_in_data = '0; r4_in_valid = '0; r4_sel = '0; r4_out_ready = 1'b0;
        r3_in_data = '0; r3_in_valid = '0; r3_sel = '0; r3_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        checks++;
        if (s4_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %0b want 0", s4_out_valid);
        end
        checks++;
        if (s4_out_data !== 32'h0) begin
            failures++; $display("FAIL reset_out_data: got %08h want 00000000", s4_out_data);
        end
        checks++;
        if (s4_out_chan !== 2'd0) begin
            failures++; $display("FAIL reset_out_chan: got %0d want 0", s4_out_chan);
        end

        // Load a word into s4 and move the r4 pointer away from 0.
        rst = 1'b0;
        s4_sel = 2'd1;
        s4_in_data[1*W +: W] = 32'hDEAD_BEEF;
        s4_in_valid = 4'b0010;
        r4_in_valid = 4'b1111;
        r4_out_ready = 1'b1;
        @(negedge clk);
        s4_in_valid = 4'b0000;

        checks++;
        if (s4_out_valid !== 1'b1 || s4_out_data !== 32'hDEAD_BEEF || s4_out_chan !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset_load: got v=%0b d=%08h c=%0d want v=1 d=deadbeef c=1",
                     s4_out_valid, s4_out_data, s4_out_chan);
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s4_out_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset_valid: got %0b want 0", s4_out_valid);
        end
        checks++;
        if (s4_out_data !== 32'h0) begin
            failures++; $display("FAIL async_reset_data: got %08h want 00000000", s4_out_data);
        end
        checks++;
        if (s4_out_chan !== 2'd0) begin
            failures++; $display("FAIL async_reset_chan: got %0d want 0", s4_out_chan);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (r4_in_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_ptr_zero: got in_ready=%b want 0001", r4_in_ready);
        end
        r4_in_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_sel_basic();
        s4_sel = 2'd2;
        s4_in_data[2*W +: W] = 32'h0000_00C2;
        s4_in_valid = 4'b0100;
        s4_out_ready = 1'b1;
        #1;
        checks++;
        if (s4_in_ready !== 4'b0100) begin
            failures++; $display("FAIL sel_in_ready: got %b want 0100", s4_in_ready);
        end
        @(negedge clk);
        checks++;
        if (s4_out_valid !== 1'b1 || s4_out_data !== 32'h0000_00C2 || s4_out_chan !== 2'd2) begin
            failures++;
            $display("FAIL sel_output: got v=%0b d=%08h c=%0d want v=1 d=000000c2 c=2",
                     s4_out_valid, s4_out_data, s4_out_chan);
        end
    endtask

    task automatic test_sel_backpressure();
        s4_out_ready = 1'b0;
        s4_sel = 2'd1;
        s4_in_data[1*W +: W] = 32'h0000_0011;
        s4_in_valid = 4'b0010;
        #1;
        checks++;
        if (s4_in_ready !== 4'b0000) begin
            failures++; $display("FAIL stall_in_ready: got %b want 0000", s4_in_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (s4_out_valid !== 1'b1 || s4_out_data !== 32'h0000_00C2 || s4_out_chan !== 2'd2) begin
            failures++;
            $display("FAIL stall_hold: got v=%0b d=%08h c=%0d want v=1 d=000000c2 c=2",
                     s4_out_valid, s4_out_data, s4_out_chan);
        end
        s4_in_valid = 4'b0000;
        s4_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s4_out_valid !== 1'b0 || s4_out_data !== 32'h0000_00C2 || s4_out_chan !== 2'd2) begin
            failures++;
            $display("FAIL drain_only: got v=%0b d=%08h c=%0d want v=0 d=000000c2 c=2",
                     s4_out_valid, s4_out_data, s4_out_chan);
        end
    endtask

    task automatic test_illegal_sel();
        s3_sel = 2'd3;
        s3_in_data = {32'h0000_0032, 32'h0000_0031, 32'h0000_0030};
        s3_in_valid = 3'b111;
        s3_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (s3_in_ready !== 3'b000 || s3_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL illegal_sel cycle %0d: got in_ready=%b out_valid=%0b want 000 0",
                         c, s3_in_ready, s3_out_valid);
            end
            @(negedge clk);
        end
        s3_in_valid = 3'b000;
    endtask

    task automatic test_rr_fairness();
        for (int i = 0; i < 4; i++) begin
            r4_in_data[i*W +: W] = 32'h0000_00A0 + i;
        end
        r4_in_valid = 4'b1111;
        r4_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (r4_out_valid !== 1'b1 || r4_out_chan !== 2'(k % 4)
                || r4_out_data !== 32'h0000_00A0 + 32'(k % 4)) begin
                failures++;
                $display("FAIL rr_fair step %0d: got v=%0b c=%0d d=%08h want v=1 c=%0d d=%08h",
                         k, r4_out_valid, r4_out_chan, r4_out_data, k % 4, 32'h0000_00A0 + 32'(k % 4));
            end
        end
        r4_in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (r4_out_valid !== 1'b0) begin
            failures++; $display("FAIL rr_fair_drain: got %0b want 0", r4_out_valid);
        end
    endtask

    task automatic test_rr_skip_wrap();
        r3_in_data = {32'h0000_0032, 32'h0000_0031, 32'h0000_0030};
        r3_out_ready = 1'b1;
        r3_in_valid = 3'b010;
        @(negedge clk);
        checks++;
        if (r3_out_chan !== 2'd1) begin
            failures++; $display("FAIL rr_setup_chan: got %0d want 1", r3_out_chan);
        end
        r3_in_valid = 3'b011;
        #1;
        checks++;
        if (r3_in_ready !== 3'b001) begin
            failures++; $display("FAIL rr_wrap_grant: got %b want 001", r3_in_ready);
        end
        @(negedge clk);
        checks++;
        if (r3_out_chan !== 2'd0 || r3_out_data !== 32'h0000_0030) begin
            failures++;
            $display("FAIL rr_wrap_out: got c=%0d d=%08h want c=0 d=00000030", r3_out_chan, r3_out_data);
        end
        #1;
        checks++;
        if (r3_in_ready !== 3'b010) begin
            failures++; $display("FAIL rr_ptr_one: got %b want 010", r3_in_ready);
        end
        @(negedge clk);
        checks++;
        if (r3_out_chan !== 2'd1 || r3_out_valid !== 1'b1) begin
            failures++; $display("FAIL rr_second_out: got c=%0d v=%0b want c=1 v=1", r3_out_chan, r3_out_valid);
        end
        r3_in_valid = 3'b111;
        #1;
        checks++;
        if (r3_in_ready !== 3'b100) begin
            failures++; $display("FAIL rr_ptr_two: got %b want 100", r3_in_ready);
        end
        r3_in_valid = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_drain_refill();
        int xfers;
        xfers = 0;
        s4_sel = 2'd0;
        s4_in_data[0*W +: W] = 32'h0000_0100;
        s4_in_valid = 4'b0001;
        s4_out_ready = 1'b1;
        @(negedge clk);
        s4_sel = 2'd1;
        s4_in_data[1*W +: W] = 32'h0000_0201;
        s4_in_valid = 4'b0010;
        #1;
        checks++;
        if (s4_in_ready !== 4'b0010) begin
            failures++; $display("FAIL refill_in_ready: got %b want 0010", s4_in_ready);
        end
        xfers += $countones(s4_in_ready & s4_in_valid);
        @(negedge clk);
        s4_in_valid = 4'b0000;
        #1;
        xfers += $countones(s4_in_ready & s4_in_valid);
        checks++;
        if (s4_out_valid !== 1'b1 || s4_out_data !== 32'h0000_0201 || s4_out_chan !== 2'd1) begin
            failures++;
            $display("FAIL refill_out: got v=%0b d=%08h c=%0d want v=1 d=00000201 c=1",
                     s4_out_valid, s4_out_data, s4_out_chan);
        end
        checks++;
        if (xfers !== 1) begin
            failures++; $display("FAIL refill_count: got %0d want 1", xfers);
        end
        @(negedge clk);
        checks++;
        if (s4_out_valid !== 1'b0) begin
            failures++; $display("FAIL refill_drain: got %0b want 0", s4_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_sel_backpressure();
        test_illegal_sel();
        test_rr_fairness();
        test_rr_skip_wrap();
        test_drain_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
